// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with optional two's-complement input; result valid DATA_WIDTH cycles after accept.
// Single word in flight: o_ready is low until the finished result has been taken downstream, and the result holds while i_ready is low.
module bcd_converter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_2s_comp,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_negative,
  output logic                    o_valid,
  input  logic                    i_ready
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [DATA_WIDTH-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mag_q;
  logic [BW-1:0]         bcd_q;
  logic [CW-1:0]         cnt_q;
  logic                  neg_q;

  logic                  in_neg;
  logic [DATA_WIDTH-1:0] in_mag;
  logic [BW-1:0]         bcd_adj;
  logic [BW-1:0]         bcd_shift;
  logic                  accept;
  logic                  last_iter;

  assign in_neg = i_2s_comp && i_data[DATA_WIDTH-1];
  // Unsigned negate so the most negative input maps to its full magnitude.
  assign in_mag = in_neg ? (~i_data + ONE) : i_data;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_shift = {bcd_adj[BW-2:0], mag_q[DATA_WIDTH-1]};
  assign accept    = i_valid && o_ready;
  assign last_iter = (cnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      o_bcd      <= '0;
      o_negative <= 1'b0;
    end else if (accept) begin
      mag_q <= in_mag;
      bcd_q <= '0;
      cnt_q <= CW'(DATA_WIDTH);
      neg_q <= in_neg;
    end else if (state_q == CONVERT) begin
      mag_q <= {mag_q[DATA_WIDTH-2:0], 1'b0};
      bcd_q <= bcd_shift;
      cnt_q <= cnt_q - CW'(1);
      // The final iteration publishes its shifted value straight to the output.
      if (last_iter) begin
        o_bcd      <= bcd_shift;
        o_negative <= neg_q;
      end
    end
  end

endmodule

// File: doc/bcd_converter.md
Name: bcd_converter

Overview:
- Sequential double-dabble binary-to-BCD converter between the calculator core's display output and the 7-segment shift-register driver.
- Accepts one DATA_WIDTH result word, plus a two's-complement mode flag, through a valid/ready handshake.
- Produces an unsigned magnitude as NUM_DIGITS packed BCD digits plus a separate sign flag.
- Hands the result downstream through a second valid/ready handshake.

Parameters:
- DATA_WIDTH, 16: width of the binary input word.
- NUM_DIGITS, 5: number of BCD output digits. Requires 10^NUM_DIGITS > 2^DATA_WIDTH - 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- i_data  input  DATA_WIDTH  binary value to convert.
- i_2s_comp  input  1  1 = treat i_data as two's complement; 0 = unsigned.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  converter can accept a word.
- o_bcd  output  4*NUM_DIGITS  packed BCD magnitude; digit 0 (ones) is in bits [3:0].
- o_negative  output  1  result is negative.
- o_valid  output  1  o_bcd/o_negative hold a finished result.
- i_ready  input  1  downstream accepts the result.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state = IDLE, o_ready = 1, o_valid = 0, o_bcd = 0, o_negative = 0.
  - Iteration counter = 0; internal shift/BCD registers = 0.
- States:
  - IDLE: o_ready = 1, o_valid = 0.
  - CONVERT: o_ready = 0, o_valid = 0.
  - DONE: o_ready = 0, o_valid = 1.
- IDLE -> CONVERT on i_valid && o_ready at a clock edge. At that edge:
  - Capture magnitude: (i_2s_comp && i_data[DATA_WIDTH-1]) ? (2^DATA_WIDTH - i_data) : i_data. This is computed as an unsigned DATA_WIDTH value, so 0x8000 yields magnitude 32768 (no overflow).
  - Capture negative = i_2s_comp && i_data[DATA_WIDTH-1].
  - Clear the working BCD register; load counter = DATA_WIDTH.
- CONVERT, one iteration per cycle:
  - Every working digit >= 5 gets +3 (all digits in parallel, combinational).
  - Then shift {bcd, magnitude} left by one; the magnitude MSB enters bcd bit 0.
  - Decrement counter. After the iteration that brings counter to 0, go to DONE.
- Entering DONE: o_bcd <= working BCD register, o_negative <= captured sign.
- o_bcd and o_negative change only on entry to DONE or on reset. They hold their last result through IDLE and CONVERT.
- DONE -> IDLE on o_valid && i_ready. o_ready rises the cycle after the downstream handshake; there is no same-cycle turnaround.
- Latency:
  - Accept at edge N; o_valid high after edge N+DATA_WIDTH (16 cycles at default).
  - Throughput: one word per DATA_WIDTH+2 cycles when i_ready is tied high.
- Outputs are stable while o_valid = 1 and i_ready = 0; hold indefinitely.
- i_data and i_2s_comp are sampled only at the accept edge. Changes during CONVERT or DONE have no effect.
- i_valid while not in IDLE is ignored (o_ready = 0); upstream must hold it.
- Zero: o_bcd = 0 and o_negative = 0 in both modes; negative zero cannot occur.
- Reset mid-CONVERT or mid-DONE: immediate return to reset values; the partial result is discarded and no o_valid pulse is produced.
- Digits above the value's magnitude read 0 (leading zeros are not blanked here; blanking belongs to the display driver).

Test Plan:
- Unsigned: i_data = 0xFFFF, i_2s_comp = 0, i_ready = 1 -> exactly 16 cycles after accept, o_valid = 1, o_bcd = 0x65535, o_negative = 0; o_ready high one cycle after the handshake.
- Signed min: i_data = 0x8000, i_2s_comp = 1 -> o_bcd = 0x32768, o_negative = 1. Same data with i_2s_comp = 0 -> o_bcd = 0x32768, o_negative = 0.
- Signed negative and zero:
  - i_data = 0xFFFF, i_2s_comp = 1 -> o_bcd = 0x00001, o_negative = 1.
  - i_data = 0x0000, i_2s_comp = 1 -> o_bcd = 0x00000, o_negative = 0.
- Backpressure: i_ready = 0 for 20 cycles after o_valid with i_data = 12345 -> o_bcd = 0x12345 held stable, o_ready = 0, and a new i_valid is not accepted. Raise i_ready -> one transfer, o_ready = 1 next cycle.
- Input stability: change i_data from 999 to 0x1234 while in CONVERT -> result is 0x00999.
- Reset: assert rst_n low at cycle 8 of CONVERT -> o_valid = 0, o_ready = 1, o_bcd = 0 immediately. A subsequent conversion of 42 yields 0x00042.
